// File: rtl/rib_sram_slave_pkg.sv
// Shared RIB bus definitions used by the SRAM slave and its response FIFO.
package rib_sram_slave_pkg;

  typedef enum logic {
    RIB_RD = 1'b0,
    RIB_WR = 1'b1
  } rib_op_e;

  typedef logic [31:0] xlen_def;
  typedef logic [31:0] ribdatalen_def;

endpackage

// File: rtl/rib_rsp_fifo.sv
// Two-entry in-order response buffer for RIB slaves; head is the oldest entry.
module rib_rsp_fifo
  import rib_sram_slave_pkg::*;
(
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  ribdatalen_def data_i,
  output logic [1:0]    count_o,
  output ribdatalen_def head_o
);

  ribdatalen_def entries_q [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop_i;
    wr_ptr_d = wr_ptr_q ^ push_i;
    count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      entries_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = entries_q[rd_ptr_q];

endmodule

// File: rtl/rib_sram_slave.sv
// RIB responder around a single-port word SRAM: one-cycle access stage feeding
// a 2-entry response FIFO, with a credit-based grant so the FIFO never overflows.
module rib_sram_slave
  import rib_sram_slave_pkg::*;
#(
  parameter  int MEM_WORDS = 4096,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_ribs_addr,
  input  logic        i_ribs_wrcs,
  input  logic [3:0]  i_ribs_mask,
  input  logic [31:0] i_ribs_wdata,
  input  logic        i_ribs_req,
  output logic        o_ribs_gnt,
  output logic [31:0] o_ribs_rdata,
  output logic        o_ribs_rsp,
  input  logic        i_ribs_rdy
);

  logic [31:0]   mem [0:MEM_WORDS-1];
  logic [AW-1:0] idx;
  logic          accept;
  logic          is_wr;
  logic          rsp_pop;
  logic [2:0]    occupancy;
  logic          unused_addr_bits;

  logic          s1_vld_q, s1_vld_d;
  logic          s1_is_wr_q, s1_is_wr_d;
  ribdatalen_def sram_rdata_q;

  logic [1:0]    fifo_count;
  ribdatalen_def fifo_head;
  ribdatalen_def fifo_push_data;

  assign idx              = i_ribs_addr[AW+1:2];
  assign unused_addr_bits = ^{i_ribs_addr[31:AW+2], i_ribs_addr[1:0]};
  assign is_wr            = (i_ribs_wrcs == RIB_WR);

  // Credit counts the access stage plus buffered entries, freeing a slot in the
  // same cycle the master pops so back-to-back traffic is not throttled.
  assign rsp_pop    = o_ribs_rsp & i_ribs_rdy;
  assign occupancy  = {2'b00, s1_vld_q} + {1'b0, fifo_count} - {2'b00, rsp_pop};
  assign o_ribs_gnt = (occupancy < 3'd2);
  assign accept     = i_ribs_req & o_ribs_gnt & i_rstn;

  always_comb begin
    s1_vld_d   = accept;
    s1_is_wr_d = is_wr;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s1_vld_q   <= 1'b0;
      s1_is_wr_q <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_is_wr_q <= s1_is_wr_d;
    end
  end

  // Writes land at the accepting edge, so a read accepted one edge later sees them.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      if (is_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (i_ribs_mask[b]) begin
            mem[idx][8*b +: 8] <= i_ribs_wdata[8*b +: 8];
          end
        end
      end else begin
        sram_rdata_q <= mem[idx];
      end
    end
  end

  assign fifo_push_data = s1_is_wr_q ? '0 : sram_rdata_q;

  rib_rsp_fifo u_rsp_fifo (
    .clk_i   (i_clk),
    .rstn_i  (i_rstn),
    .push_i  (s1_vld_q),
    .pop_i   (rsp_pop),
    .data_i  (fifo_push_data),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign o_ribs_rsp   = (fifo_count != 2'd0);
  assign o_ribs_rdata = o_ribs_rsp ? fifo_head : '0;

endmodule

// File: tb/tb_rib_sram_slave.sv
// Randomised scoreboard bench for rib_sram_slave against a word-array memory model.
module tb_rib_sram_slave;

  localparam int MEM_WORDS = 64;

  typedef struct {
    logic [31:0] data;
    bit          known;
    int          edgeNo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] addr = '0;
  logic        wrcs = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] wdata = '0;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] rdata;
  logic        rsp;
  logic        rdy = 1'b1;

  int          checkCount = 0;
  int          failCount = 0;
  int          cyc = 0;
  int          rdyMode = 1;
  int          lastPopEdge = 0;
  int          lastAcceptEdge = 0;
  int          thirdEdge = 0;
  bit          thirdDone = 0;
  bit          headSeen = 0;
  exp_t        expQ[$];
  logic [31:0] refMem [int];

  rib_sram_slave #(.MEM_WORDS(MEM_WORDS)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_ribs_addr  (addr),
    .i_ribs_wrcs  (wrcs),
    .i_ribs_mask  (mask),
    .i_ribs_wdata (wdata),
    .i_ribs_req   (req),
    .o_ribs_gnt   (gnt),
    .o_ribs_rdata (rdata),
    .o_ribs_rsp   (rsp),
    .i_ribs_rdy   (rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdyMode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic reportFail(input string name, input string msg);
    checkCount++;
    failCount++;
    $display("[TB] FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // Reference memory: plain byte merge into a word array indexed modulo depth.
  task automatic modelWrite(input int idx, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] w;
    w = refMem.exists(idx) ? refMem[idx] : 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    end
    refMem[idx] = w;
  endtask

  // Issues one request, holding it until granted; called at posedge+1.
  task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    int   waited;
    bit   done;
    int   idx;
    exp_t e;
    waited = 0;
    done   = 0;
    req    = 1'b1;
    wrcs   = wr;
    addr   = a;
    mask   = m;
    wdata  = d;
    while (!done) begin
      @(negedge clk);
      if (gnt === 1'b1 && rstn === 1'b1) begin
        idx = int'((a >> 2) % MEM_WORDS);
        if (wr) begin
          modelWrite(idx, m, d);
          e.data  = 32'h0;
          e.known = 1'b1;
        end else begin
          e.known = refMem.exists(idx);
          e.data  = e.known ? refMem[idx] : 32'h0;
        end
        e.edgeNo = cyc + 1;
        @(posedge clk);
        expQ.push_back(e);
        lastAcceptEdge = e.edgeNo;
        done = 1;
      end else begin
        waited++;
        if (waited > 500) begin
          reportFail("grantTimeout", "request never granted");
          done = 1;
        end
        @(posedge clk);
      end
    end
    #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int waited;
    rdyMode = 1;
    waited  = 0;
    while (expQ.size() > 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    if (expQ.size() > 0) reportFail("drainTimeout", $sformatf("%0d responses outstanding", expQ.size()));
    #1;
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkOutput({tag, "Gnt"}, {31'h0, gnt}, 32'h1);
    checkOutput({tag, "Rsp"}, {31'h0, rsp}, 32'h0);
    checkOutput({tag, "Rdata"}, rdata, 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Reset for n edges, optionally presenting a write that must be ignored.
  task automatic resetDut(input int n, input bit reqDuring, input logic [31:0] a, input logic [31:0] d);
    rstn = 1'b0;
    if (reqDuring) begin
      req   = 1'b1;
      wrcs  = 1'b1;
      addr  = a;
      mask  = 4'hF;
      wdata = d;
    end
    repeat (n) @(posedge clk);
    expQ.delete();
    headSeen    = 0;
    lastPopEdge = 0;
    #1;
    rstn = 1'b1;
    req  = 1'b0;
  endtask

  // Monitor: credit model, in-order data, response latency and idle outputs.
  always @(negedge clk) begin
    bit   popNow;
    int   visEdge;
    exp_t f;
    if (rstn === 1'b1) begin
      popNow = (rsp === 1'b1) && (rdy === 1'b1);
      checkOutput("gntCredit", {31'h0, gnt}, {31'h0, (expQ.size() - int'(popNow)) < 2});
      if (expQ.size() == 0) begin
        checkOutput("rspIdle", {31'h0, rsp}, 32'h0);
        checkOutput("rdataIdle", rdata, 32'h0);
      end else begin
        f = expQ[0];
        visEdge = maxi(f.edgeNo + 1, lastPopEdge);
        if (rsp === 1'b1) begin
          if (!headSeen) begin
            checkOutput("rspLatency", cyc, visEdge);
            headSeen = 1;
          end
          if (f.known) checkOutput("rspData", rdata, f.data);
          if (popNow) begin
            void'(expQ.pop_front());
            lastPopEdge = cyc + 1;
            headSeen    = 0;
          end
        end else begin
          checkOutput("rspPending", {31'h0, visEdge > cyc}, 32'h1);
          checkOutput("rdataNoRsp", rdata, 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount + 1, failCount + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ra;
    int          idx;
    rdyMode = 1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    checkIdle("reset");

    // Full write then immediate read of the same word.
    applyStimulus(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h10, 4'h0, 32'h0);
    drain();

    // Byte-masked write over existing data.
    applyStimulus(1'b1, 32'h10, 4'b0101, 32'h11223344);
    applyStimulus(1'b0, 32'h10, 4'h0, 32'h0);
    drain();

    // Backpressure: two outstanding, third waits for the first pop.
    rdyMode = 0;
    idle(1);
    applyStimulus(1'b0, 32'h10, 4'h0, 32'h0);
    applyStimulus(1'b1, 32'h14, 4'hF, 32'h0BADF00D);
    thirdDone = 0;
    fork
      begin
        applyStimulus(1'b0, 32'h14, 4'h0, 32'h0);
        thirdEdge = lastAcceptEdge;
        thirdDone = 1;
      end
    join_none
    repeat (5) @(posedge clk);
    checkOutput("thirdHeld", {31'h0, thirdDone}, 32'h0);
    rdyMode = 1;
    wait fork;
    checkOutput("thirdGrantEdge", thirdEdge, lastPopEdge);
    drain();

    // Address aliasing and ignored low bits.
    applyStimulus(1'b1, 32'h0, 4'hF, 32'hA5A5A5A5);
    applyStimulus(1'b0, MEM_WORDS * 4 + 3, 4'h0, 32'h0);
    drain();

    // Reset with two buffered responses and a write presented during reset.
    rdyMode = 0;
    idle(1);
    applyStimulus(1'b0, 32'h10, 4'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0);
    idle(2);
    resetDut(1, 1'b1, 32'h10, 32'hBAD0BAD0);
    checkIdle("midReset");
    rdyMode = 1;
    applyStimulus(1'b0, 32'h10, 4'h0, 32'h0);
    drain();

    // Randomised traffic over a 16-word region with random rdy.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, i * 4, 4'hF, $urandom);
    rdyMode = 2;
    for (int i = 0; i < 250; i++) begin
      idx = $urandom_range(0, 15);
      ra  = ($urandom & 32'hFFFF_FF03) | (idx << 2);
      applyStimulus(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();
    checkOutput("finalQueueEmpty", expQ.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/rib_sram_slave.md
# rib_sram_slave

RIB bus responder wrapping a single-port synchronous word SRAM; the slave-side counterpart of the core's ibus/dbus RIB masters. It accepts one request per cycle, performs byte-masked writes or word reads, and returns every request's response in order through a 2-entry response buffer. Master backpressure is absorbed there, and `o_ribs_gnt` throttles new requests. It sits behind the RIB interconnect as instruction/data memory.

## Interface
- `MEM_WORDS`, default 4096: SRAM depth in 32-bit words; must be a power of two.
- `AW`, default `$clog2(MEM_WORDS)`: word-index width; derived, not overridden.
- `i_clk`  in  1  clock.
- `i_rstn`  in  1  reset; synchronous, active-low.
- `i_ribs_addr`  in  32  byte address; word index is `addr[AW+1:2]`; `addr[1:0]` and upper bits are ignored.
- `i_ribs_wrcs`  in  1  1 = write, 0 = read.
- `i_ribs_mask`  in  4  write byte enables; bit i enables byte i (`wdata[8i+7:8i]`).
- `i_ribs_wdata`  in  32  write data.
- `i_ribs_req`  in  1  master request valid.
- `o_ribs_gnt`  out  1  request accepted this cycle if `req`.
- `o_ribs_rdata`  out  32  response data: read data, or 0 for write responses.
- `o_ribs_rsp`  out  1  response valid.
- `i_ribs_rdy`  in  1  master accepts the response this cycle.

## Operation
- Accept: a request is accepted when `req & gnt` at a rising edge.
- Read acceptance: the SRAM is read at the accepting edge. Stage S1 (`s1_vld`, `s1_is_wr`) holds the access for one cycle. Data is pushed into the response FIFO at the next edge.
- Write acceptance: the SRAM bytes are written at the accepting edge, only those with mask=1. S1 carries a write-response marker; the FIFO entry's rdata is 0.
- Mask 0000 on a write: no bytes change, but a response is still returned.
- Response FIFO: 2 entries, in-order.
  - `o_ribs_rsp = ~empty`; `o_ribs_rdata` = head entry, or 0 when empty.
  - Pop on `rsp & rdy`.
  - Head data is stable while `rsp & ~rdy`.
- Credit: `o_ribs_gnt = (s1_vld + fifo_count - (rsp & rdy)) < 2`.
  - Combinational from state and `i_ribs_rdy` only; must never depend on `i_ribs_req`.
  - The FIFO can therefore never overflow.
- Ordering: responses leave in acceptance order. A read accepted the cycle after a write to the same word returns the new data (write-then-read coherence via the edge ordering).
- Address wrap: index bits above `AW+1` are dropped. Address `MEM_WORDS*4` aliases word 0.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (`i_rstn`=0 at an edge): `s1_vld`=0, FIFO empty.
  - Outputs afterwards: `rsp`=0, `rdata`=0, `gnt`=1.
  - Any in-flight or buffered responses are discarded. SRAM contents are retained.
  - A request presented during reset is not accepted. No write occurs while `i_rstn`=0.
- Latency: request accepted at edge E gives `rsp`=1 in the cycle after edge E+1 (2 cycles), when the FIFO is empty and `rdy`=1.
- Throughput: 1 request/cycle sustained with `rdy` held 1.
- Backpressure with `rdy`=0: at most 2 outstanding.
  - Pattern: accept, accept, then `gnt`=0 until a pop.
  - In a cycle with `rsp & rdy`, `gnt` can reassert the same cycle.
- Simultaneous FIFO push (from S1) and pop: count unchanged; the head advances correctly.
- Empty FIFO with S1 valid: the entry becomes visible the next cycle; there is no combinational bypass.

## Structure
- Shared defines file: add `RIB_WR` (1'b1), `RIB_RD` (1'b0), and `ribdatalen_def` [31:0] alongside the existing `xlen_def`.
- Sub-module `rib_rsp_fifo`: 2-entry, 32-bit synchronous FIFO with push, pop, count[1:0], head, and sync active-low reset. It is reusable by other RIB slaves.
- The SRAM is inferred inline as a `reg [31:0] mem[0:MEM_WORDS-1]` with a registered read. Byte writes are per-lane.

## Test plan
- Reset then idle: `rstn`=0 for 2 cycles, then 1 → `gnt`=1, `rsp`=0, `rdata`=0.
- Write 0xDEADBEEF to 0x10 with mask 1111, then read 0x10 the next cycle → write response `rdata`=0, then read response 0xDEADBEEF. Responses arrive 2 cycles after each accept, with no gap.
- Masked write 0x11223344 to 0x10 with mask 0101 over 0xDEADBEEF, then read → 0xDE22BE44.
- Backpressure: `rdy`=0 with 3 back-to-back reads → first two granted, third sees `gnt`=0. Head stays stable for 5 cycles. Raising `rdy` drains both responses in order, and the third read is granted in the first pop cycle.
- Alias/ignored bits: write 0xA5A5A5A5 to 0x0, then read `MEM_WORDS*4 + 3` → 0xA5A5A5A5.
- Reset mid-flight: 2 responses buffered with `rdy`=0, assert reset → `rsp`=0 next cycle, `gnt`=1. A subsequent read of a previously written word returns the stored data.
